sc_plateau_trigger: RTL and testbench

// Parametrised Schmidl&Cox plateau detector and trigger generator. Consumes the
// Q1.14 timing metric and the matching CORDIC phase stream in lockstep. Emits one
// {trigger, phase} beat per input pair to the framer and phase accumulator.

---
 rtl/sc_plateau_trigger.sv | 161 ++++++++++++++++
 tb/tb_sc_plateau_trigger.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_plateau_trigger.sv
// Schmidl&Cox plateau detector: joins metric and phase streams, counts a run of
// metric samples at or above threshold and emits a one-beat trigger followed by holdoff.
module sc_plateau_trigger #(
    parameter int         WIDTH_METRIC   = 16,
    parameter int         WIDTH_PHASE    = 24,
    parameter int         WIDTH_TRIG     = 16,
    parameter int         MAX_LEN_LOG2   = 10,
    parameter logic [7:0] SR_THRESHOLD   = 8'd0,
    parameter logic [7:0] SR_PLATEAU_LEN = 8'd1,
    parameter logic [7:0] SR_HOLDOFF     = 8'd2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                set_stb,
    input  logic [7:0]                          set_addr,
    input  logic [31:0]                         set_data,
    input  logic [WIDTH_METRIC-1:0]             d_metric_tdata,
    input  logic                                d_metric_tlast,
    input  logic                                d_metric_tvalid,
    output logic                                d_metric_tready,
    input  logic [WIDTH_PHASE-1:0]              phase_tdata,
    input  logic                                phase_tvalid,
    output logic                                phase_tready,
    output logic [WIDTH_TRIG+WIDTH_PHASE-1:0]   o_tdata,
    output logic                                o_tlast,
    output logic                                o_tvalid,
    input  logic                                o_tready,
    input  logic                                eof
);

    localparam logic [0:0] ST_SEARCH  = 1'b0;
    localparam logic [0:0] ST_HOLDOFF = 1'b1;

    localparam logic [MAX_LEN_LOG2-1:0] RUN_MAX  = {MAX_LEN_LOG2{1'b1}};
    localparam logic [MAX_LEN_LOG2-1:0] PLEN_RST = MAX_LEN_LOG2'(64);
    localparam logic [MAX_LEN_LOG2-1:0] HOLD_RST = MAX_LEN_LOG2'(160);

    function automatic logic [MAX_LEN_LOG2-1:0] sat_inc(input logic [MAX_LEN_LOG2-1:0] v);
        return (v == RUN_MAX) ? v : v + MAX_LEN_LOG2'(1);
    endfunction

    logic [WIDTH_METRIC-1:0]   thr;
    logic [MAX_LEN_LOG2-1:0]   plen;
    logic [MAX_LEN_LOG2-1:0]   holdoff;

    logic [0:0]                state, state_nxt;
    logic [MAX_LEN_LOG2-1:0]   run_cnt, run_nxt;
    logic [MAX_LEN_LOG2-1:0]   hcnt, hcnt_nxt;
    logic [WIDTH_PHASE-1:0]    held_phase;
    logic                      eof_pend;

    logic                      out_free, fire, eof_eff, trig_p0, above_p0, eval_search;
    logic [MAX_LEN_LOG2-1:0]   plen_eff, run_base, run_inc;
    logic signed [WIDTH_METRIC-1:0] metric_s, thr_s;
    logic                      unused_set_bits;

    assign unused_set_bits = ^set_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr     <= '0;
            plen    <= PLEN_RST;
            holdoff <= HOLD_RST;
        end else if (set_stb) begin
            case (set_addr)
                SR_THRESHOLD:   thr     <= set_data[WIDTH_METRIC-1:0];
                SR_PLATEAU_LEN: plen    <= set_data[MAX_LEN_LOG2-1:0];
                SR_HOLDOFF:     holdoff <= set_data[MAX_LEN_LOG2-1:0];
                default: ;
            endcase
        end
    end

    // Join: both streams pop together only when the output register can take a beat.
    assign out_free        = ~o_tvalid | o_tready;
    assign d_metric_tready = out_free & phase_tvalid & ~clear;
    assign phase_tready    = out_free & d_metric_tvalid & ~clear;
    assign fire            = d_metric_tvalid & phase_tvalid & out_free & ~clear;

    assign metric_s = d_metric_tdata;
    assign thr_s    = thr;
    assign above_p0 = metric_s >= thr_s;
    assign plen_eff = (plen == '0) ? MAX_LEN_LOG2'(1) : plen;
    // An eof seen during a stall is remembered so it still acts on the next fire.
    assign eof_eff  = eof | eof_pend;

    always_comb begin
        state_nxt   = state;
        run_nxt     = run_cnt;
        hcnt_nxt    = hcnt;
        trig_p0     = 1'b0;
        eval_search = 1'b0;
        run_base    = run_cnt;
        run_inc     = '0;
        if (state == ST_HOLDOFF) begin
            run_base = '0;
            if (eof_eff) begin
                eval_search = 1'b1;
            end else if (hcnt == '0) begin
                state_nxt = ST_SEARCH;
                run_nxt   = '0;
            end else begin
                hcnt_nxt = hcnt - MAX_LEN_LOG2'(1);
            end
        end else begin
            eval_search = 1'b1;
        end
        if (eval_search) begin
            state_nxt = ST_SEARCH;
            run_inc   = sat_inc(run_base);
            if (!above_p0) begin
                run_nxt = '0;
            end else if (run_inc == plen_eff) begin
                trig_p0   = 1'b1;
                state_nxt = ST_HOLDOFF;
                hcnt_nxt  = holdoff;
                run_nxt   = '0;
            end else begin
                run_nxt = run_inc;
            end
        end
    end

    // Output register stage: one beat per consumed pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_SEARCH;
            run_cnt    <= '0;
            hcnt       <= '0;
            held_phase <= '0;
            eof_pend   <= 1'b0;
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            o_tlast    <= 1'b0;
        end else if (clear) begin
            state      <= ST_SEARCH;
            run_cnt    <= '0;
            hcnt       <= '0;
            held_phase <= '0;
            eof_pend   <= 1'b0;
            o_tvalid   <= 1'b0;
        end else if (fire) begin
            state    <= state_nxt;
            run_cnt  <= run_nxt;
            hcnt     <= hcnt_nxt;
            eof_pend <= 1'b0;
            o_tvalid <= 1'b1;
            o_tlast  <= d_metric_tlast;
            o_tdata  <= {WIDTH_TRIG'(trig_p0), trig_p0 ? phase_tdata : held_phase};
            if (trig_p0)
                held_phase <= phase_tdata;
        end else begin
            if (o_tready)
                o_tvalid <= 1'b0;
            if (eof && state == ST_HOLDOFF)
                eof_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sc_plateau_trigger.sv
// Bench for sc_plateau_trigger: table of plateau scenarios, random throttling
// against a reference model, and hand sequences for eof, clear and async reset.
module tb_sc_plateau_trigger;

    logic        clk = 1'b0;
    logic        reset, clear, set_stb, eof;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] d_metric_tdata;
    logic        d_metric_tlast, d_metric_tvalid, d_metric_tready;
    logic [23:0] phase_tdata;
    logic        phase_tvalid, phase_tready;
    logic [39:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready;

    always #5 clk = ~clk;

    sc_plateau_trigger dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .d_metric_tdata(d_metric_tdata), .d_metric_tlast(d_metric_tlast),
        .d_metric_tvalid(d_metric_tvalid), .d_metric_tready(d_metric_tready),
        .phase_tdata(phase_tdata), .phase_tvalid(phase_tvalid), .phase_tready(phase_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .eof(eof)
    );

    typedef struct {
        string       name;
        logic [15:0] thr;
        int          plen;
        int          hold;
        int          mode;   // 0 constant, 1 dip at index 63, 2 random
        logic [15:0] mval;
        int          n;
        int          ntrig;
        int          t0;
        int          t1;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] s_metric[2048];
    logic [23:0] s_phase[2048];
    logic        s_last[2048];
    logic        s_eof[2048];
    logic [40:0] exp_beat[2048];
    logic [40:0] got_q[$];
    logic [40:0] ref_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always @(negedge clk)
        if (!reset && !clear && o_tvalid && o_tready)
            got_q.push_back({o_tlast, o_tdata});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic add_vec(input string nm, input logic [15:0] thr, input int plen, input int hold,
                           input int mode, input logic [15:0] mval, input int n,
                           input int ntrig, input int t0, input int t1);
        vec_t v;
        v.name = nm; v.thr = thr; v.plen = plen; v.hold = hold; v.mode = mode;
        v.mval = mval; v.n = n; v.ntrig = ntrig; v.t0 = t0; v.t1 = t1;
        tbl.push_back(v);
    endtask

    task automatic set_reg(input logic [7:0] addr, input int data);
        set_stb = 1'b1; set_addr = addr; set_data = data;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic configure(input logic [15:0] thr, input int plen, input int hold);
        set_reg(8'd0, {16'd0, thr});
        set_reg(8'd1, plen);
        set_reg(8'd2, hold);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        got_q.delete();
    endtask

    task automatic fill(input int n, input int mode, input logic [15:0] mval);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: s_metric[i] = mval;
                1: s_metric[i] = (i == 63) ? 16'h1000 : mval;
                default: s_metric[i] = 16'($urandom);
            endcase
            s_phase[i] = 24'(i);
            s_last[i]  = (i % 7 == 6);
            s_eof[i]   = 1'b0;
        end
    endtask

    // Reference: a trigger fires once PLATEAU_LEN consecutive searched samples are
    // at/above threshold; then HOLDOFF+1 beats are ignored unless eof re-arms early.
    task automatic model(input int n, input logic [15:0] thr, input int plen, input int hold);
        int          run = 0, remaining = 0, need;
        bit          holding = 0, counts, trig;
        logic [23:0] held = '0;
        need = (plen == 0) ? 1 : plen;
        for (int i = 0; i < n; i++) begin
            trig   = 0;
            counts = 1;
            if (holding) begin
                if (s_eof[i]) begin
                    holding = 0; run = 0;
                end else begin
                    counts = 0;
                    if (remaining == 0) begin holding = 0; run = 0; end
                    else remaining--;
                end
            end
            if (counts) begin
                if ($signed(s_metric[i]) >= $signed(thr)) begin
                    run = (run < 1023) ? run + 1 : 1023;
                    if (run == need) begin
                        trig = 1; holding = 1; remaining = hold; run = 0; held = s_phase[i];
                    end
                end else begin
                    run = 0;
                end
            end
            exp_beat[i] = {s_last[i], 15'd0, trig, held};
        end
    endtask

    task automatic run_stream(input int n, input bit throttle);
        int idx = 0, cyc = 0;
        bit took;
        while (idx < n && cyc < 20000) begin
            d_metric_tvalid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            phase_tvalid    = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            o_tready        = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            d_metric_tdata  = s_metric[idx];
            d_metric_tlast  = s_last[idx];
            phase_tdata     = s_phase[idx];
            eof             = s_eof[idx];
            @(negedge clk);
            took = d_metric_tvalid && d_metric_tready;
            @(posedge clk); #1;
            if (took) idx++;
            cyc++;
        end
        if (cyc >= 20000) check("input_timeout", 1, 0);
        d_metric_tvalid = 1'b0; phase_tvalid = 1'b0; eof = 1'b0; o_tready = 1'b1;
        for (int k = 0; k < 20 && got_q.size() < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic compare_all(input string name, input int n);
        check({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", name, i), got_q[i], exp_beat[i]);
    endtask

    task automatic trig_positions(output int cnt, output int p0, output int p1);
        cnt = 0; p0 = -1; p1 = -1;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i][39:24] == 16'd1) begin
                if (cnt == 0) p0 = i;
                else if (cnt == 1) p1 = i;
                cnt++;
            end
    endtask

    initial begin
        int cnt, p0, p1, diff;
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0; eof = 1'b0;
        d_metric_tdata = '0; d_metric_tlast = 1'b0; d_metric_tvalid = 1'b0;
        phase_tdata = '0; phase_tvalid = 1'b0; o_tready = 1'b1;
        #22;
        check("reset_tvalid", o_tvalid, 0);
        check("reset_tdata", o_tdata, 0);
        check("reset_tlast", o_tlast, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        add_vec("const",   16'h2000, 64,   160, 0, 16'h3000, 300,  2,  63,  288);
        add_vec("dip",     16'h2000, 64,   160, 1, 16'h3000, 200,  1,  127, -1);
        add_vec("neg",     16'h7FFF, 4,    3,   0, 16'h8000, 100,  0,  -1,  -1);
        add_vec("minthr",  16'h8000, 5,    7,   2, 16'h0000, 60,   5,  4,   17);
        add_vec("plen0",   16'h0000, 0,    0,   0, 16'h0000, 20,   10, 0,   2);
        add_vec("equal",   16'h1234, 3,    2,   0, 16'h1234, 18,   3,  2,   8);
        add_vec("below1",  16'h1234, 3,    2,   0, 16'h1233, 18,   0,  -1,  -1);
        add_vec("satlen",  16'h0000, 1023, 0,   0, 16'h0100, 1030, 1,  1022, -1);

        for (int k = 0; k < tbl.size(); k++) begin
            configure(tbl[k].thr, tbl[k].plen, tbl[k].hold);
            do_clear();
            fill(tbl[k].n, tbl[k].mode, tbl[k].mval);
            model(tbl[k].n, tbl[k].thr, tbl[k].plen, tbl[k].hold);
            run_stream(tbl[k].n, k[0]);
            compare_all(tbl[k].name, tbl[k].n);
            trig_positions(cnt, p0, p1);
            check({tbl[k].name, "_ntrig"}, cnt, tbl[k].ntrig);
            check({tbl[k].name, "_t0"}, p0, tbl[k].t0);
            check({tbl[k].name, "_t1"}, p1, tbl[k].t1);
        end

        // Random metrics and eof, unthrottled then throttled.
        configure(16'h1000, 6, 9);
        for (int i = 0; i < 400; i++) begin
            s_metric[i] = ($urandom_range(0, 9) < 8) ? 16'h1000 + 16'($urandom_range(0, 255))
                                                     : 16'h0C00;
            s_phase[i]  = 24'($urandom);
            s_last[i]   = 1'($urandom_range(0, 1));
            s_eof[i]    = ($urandom_range(0, 19) == 0);
        end
        model(400, 16'h1000, 6, 9);
        do_clear();
        run_stream(400, 1'b0);
        compare_all("rnd_full", 400);
        ref_q = got_q;
        do_clear();
        run_stream(400, 1'b1);
        compare_all("rnd_thr", 400);
        diff = 0;
        for (int i = 0; i < 400; i++)
            if (i >= got_q.size() || i >= ref_q.size() || got_q[i] !== ref_q[i]) diff++;
        check("rnd_equiv", diff, 0);

        // eof ten beats after a trigger re-arms; the eof beat starts the new run.
        configure(16'h2000, 8, 100);
        do_clear();
        fill(60, 0, 16'h3000);
        s_eof[17] = 1'b1;
        model(60, 16'h2000, 8, 100);
        run_stream(60, 1'b0);
        compare_all("eof", 60);
        trig_positions(cnt, p0, p1);
        check("eof_ntrig", cnt, 2);
        check("eof_t0", p0, 7);
        check("eof_t1", p1, 24);

        // clear drops a pending beat and restarts the run with held phase 0.
        configure(16'h0000, 3, 40);
        do_clear();
        fill(7, 0, 16'h0100);
        for (int i = 0; i < 7; i++) s_phase[i] = 24'(i + 100);
        run_stream(6, 1'b0);
        o_tready = 1'b0; d_metric_tvalid = 1'b1; phase_tvalid = 1'b1;
        d_metric_tdata = s_metric[6]; phase_tdata = s_phase[6];
        @(posedge clk); #1;
        d_metric_tvalid = 1'b0; phase_tvalid = 1'b0;
        @(negedge clk);
        check("clr_pending", o_tvalid, 1);
        @(posedge clk); #1;
        do_clear();
        check("clr_tvalid", o_tvalid, 0);
        set_reg(8'd1, 10);
        fill(15, 0, 16'h0100);
        model(15, 16'h0000, 10, 40);
        run_stream(15, 1'b0);
        compare_all("clr_run", 15);
        trig_positions(cnt, p0, p1);
        check("clr_t0", p0, 9);

        // Asynchronous reset mid-holdoff with a beat waiting; settings return to defaults.
        configure(16'h2000, 4, 50);
        do_clear();
        fill(8, 0, 16'h3000);
        run_stream(8, 1'b0);
        o_tready = 1'b0; d_metric_tvalid = 1'b1; phase_tvalid = 1'b1;
        @(posedge clk); #1;
        d_metric_tvalid = 1'b0; phase_tvalid = 1'b0;
        @(negedge clk);
        check("ar_pending", o_tvalid, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_tvalid", o_tvalid, 0);
        check("ar_tdata", o_tdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        got_q.delete();
        fill(70, 0, 16'h3000);
        model(70, 16'h0000, 64, 160);
        run_stream(70, 1'b0);
        compare_all("ar_dflt", 70);
        trig_positions(cnt, p0, p1);
        check("ar_t0", p0, 63);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
